soc_bootcopy_ahb3: RTL and testbench

AHB3-Lite initiator that copies a fixed block of 32-bit words from a source region (the boot ROM) to a destination region (on-chip RAM) after a start request. It drives the requester side of the same AHB3-Lite bus that the ROM and RAM respond on. It holds the core in reset until the copy completes, so the core boots from RAM.

---
 rtl/soc_ahb3_pkg.sv | 13 +
 rtl/soc_bootcopy_ahb3.sv | 133 +++++++++++++
 tb/tb_soc_bootcopy_ahb3.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_ahb3_pkg.sv
// Shared AHB3-Lite encodings for bus initiators and targets in this SoC.
package soc_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/soc_bootcopy_ahb3.sv
// Boot copy engine: moves WORDS words from boot ROM to RAM over AHB3-Lite,
// one non-overlapped single transfer at a time, holding the core until done.
module soc_bootcopy_ahb3
    import soc_ahb3_pkg::*;
#(
    parameter int              PLEN     = 32,
    parameter int              XLEN     = 32,
    parameter logic [PLEN-1:0] SRC_ADDR = 32'h0000_0000,
    parameter logic [PLEN-1:0] DST_ADDR = 32'h8000_0000,
    parameter int              WORDS    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic            core_hold_o,
    output logic            ahb3_hsel_o,
    output logic [PLEN-1:0] ahb3_haddr_o,
    output logic [XLEN-1:0] ahb3_hwdata_o,
    output logic            ahb3_hwrite_o,
    output logic [2:0]      ahb3_hsize_o,
    output logic [2:0]      ahb3_hburst_o,
    output logic [3:0]      ahb3_hprot_o,
    output logic [1:0]      ahb3_htrans_o,
    output logic            ahb3_hmastlock_o,
    input  logic [XLEN-1:0] ahb3_hrdata_i,
    input  logic            ahb3_hready_i,
    input  logic            ahb3_hresp_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_DONE, S_ERROR
    } state_t;

    // A zero-word build still needs a one-bit counter to be legal.
    localparam int            CW   = (WORDS > 0) ? $clog2(WORDS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((WORDS > 0) ? WORDS - 1 : 0);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [XLEN-1:0] buf_reg, buf_next;
    logic [PLEN-1:0] haddr_reg, haddr_next;

    function automatic logic [PLEN-1:0] word_off(input logic [CW-1:0] c);
        return PLEN'(c) << 2;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            buf_reg   <= '0;
            haddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            buf_reg   <= buf_next;
            haddr_reg <= haddr_next;
        end
    end

    // The next address is loaded one edge early so haddr is a plain register.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        buf_next   = buf_reg;
        haddr_next = haddr_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    cnt_next = '0;
                    if (WORDS == 0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RD_ADDR;
                        haddr_next = SRC_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (ahb3_hready_i) state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (ahb3_hready_i) begin
                    if (ahb3_hresp_i) begin
                        state_next = S_ERROR;
                    end else begin
                        buf_next   = ahb3_hrdata_i;
                        haddr_next = DST_ADDR + word_off(cnt_reg);
                        state_next = S_WR_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                if (ahb3_hready_i) state_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (ahb3_hready_i) begin
                    if (ahb3_hresp_i) begin
                        state_next = S_ERROR;
                    end else if (cnt_reg == LAST) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        haddr_next = SRC_ADDR + word_off(cnt_reg + 1'b1);
                        state_next = S_RD_ADDR;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    logic addr_phase;
    assign addr_phase = (state_reg == S_RD_ADDR) || (state_reg == S_WR_ADDR);

    assign busy_o           = addr_phase || (state_reg == S_RD_DATA) || (state_reg == S_WR_DATA);
    assign done_o           = (state_reg == S_DONE);
    assign error_o          = (state_reg == S_ERROR);
    assign core_hold_o      = (state_reg != S_DONE);
    assign ahb3_hsel_o      = addr_phase;
    assign ahb3_htrans_o    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb3_haddr_o     = haddr_reg;
    assign ahb3_hwdata_o    = buf_reg;
    assign ahb3_hwrite_o    = (state_reg == S_WR_ADDR) || (state_reg == S_WR_DATA);
    assign ahb3_hsize_o     = HSIZE_WORD;
    assign ahb3_hburst_o    = HBURST_SINGLE;
    assign ahb3_hprot_o     = HPROT_DATA_PRIV;
    assign ahb3_hmastlock_o = 1'b0;

endmodule

// File: tb/tb_soc_bootcopy_ahb3.sv
// Directed bench: main 4-word copy against a wait-state/error slave model,
// plus a zero-word instance and an address-wrap instance.
module tb_soc_bootcopy_ahb3;
    import soc_ahb3_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start_z, start_w;

    // main instance
    logic busy, done, error, core_hold, hsel, hwrite, hmastlock, hready, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0] hsize, hburst;
    logic [3:0] hprot;
    logic [1:0] htrans;

    // zero-word instance
    logic busy_z, done_z, error_z, hold_z, hsel_z, hwrite_z, lock_z;
    logic [31:0] haddr_z, hwdata_z;
    logic [2:0] hsize_z, hburst_z;
    logic [3:0] hprot_z;
    logic [1:0] htrans_z;

    // wrap instance
    logic busy_w, done_w, error_w, hold_w, hsel_w, hwrite_w, lock_w;
    logic [31:0] haddr_w, hwdata_w;
    logic [2:0] hsize_w, hburst_w;
    logic [3:0] hprot_w;
    logic [1:0] htrans_w;

    soc_bootcopy_ahb3 #(.WORDS(4)) dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .error_o(error), .core_hold_o(core_hold), .ahb3_hsel_o(hsel),
        .ahb3_haddr_o(haddr), .ahb3_hwdata_o(hwdata), .ahb3_hwrite_o(hwrite),
        .ahb3_hsize_o(hsize), .ahb3_hburst_o(hburst), .ahb3_hprot_o(hprot),
        .ahb3_htrans_o(htrans), .ahb3_hmastlock_o(hmastlock),
        .ahb3_hrdata_i(hrdata), .ahb3_hready_i(hready), .ahb3_hresp_i(hresp)
    );

    soc_bootcopy_ahb3 #(.WORDS(0)) dut_zero (
        .clk(clk), .rst(rst), .start_i(start_z), .busy_o(busy_z), .done_o(done_z),
        .error_o(error_z), .core_hold_o(hold_z), .ahb3_hsel_o(hsel_z),
        .ahb3_haddr_o(haddr_z), .ahb3_hwdata_o(hwdata_z), .ahb3_hwrite_o(hwrite_z),
        .ahb3_hsize_o(hsize_z), .ahb3_hburst_o(hburst_z), .ahb3_hprot_o(hprot_z),
        .ahb3_htrans_o(htrans_z), .ahb3_hmastlock_o(lock_z),
        .ahb3_hrdata_i(32'h0), .ahb3_hready_i(1'b1), .ahb3_hresp_i(1'b0)
    );

    soc_bootcopy_ahb3 #(.WORDS(4), .DST_ADDR(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .start_i(start_w), .busy_o(busy_w), .done_o(done_w),
        .error_o(error_w), .core_hold_o(hold_w), .ahb3_hsel_o(hsel_w),
        .ahb3_haddr_o(haddr_w), .ahb3_hwdata_o(hwdata_w), .ahb3_hwrite_o(hwrite_w),
        .ahb3_hsize_o(hsize_w), .ahb3_hburst_o(hburst_w), .ahb3_hprot_o(hprot_w),
        .ahb3_htrans_o(htrans_w), .ahb3_hmastlock_o(lock_w),
        .ahb3_hrdata_i(32'hA5A5_0000), .ahb3_hready_i(1'b1), .ahb3_hresp_i(1'b0)
    );

    int passed = 0, total = 0, failed = 0;
    int cyc, nz;

    // slave model for the main instance
    logic [31:0] rom [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int unsigned max_wait = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h8000_0008;
    logic        dp_valid, dp_write, dp_err, err_phase, nerr;
    logic [31:0] dp_addr;
    int unsigned wait_left, w;
    int          overlap_cnt = 0;
    int          zero_traffic = 0;
    logic [63:0] obs_q[$], exp_q[$];
    logic [31:0] waddr_q[$], wexp_q[$];

    always @(posedge clk) begin
        if (htrans == HTRANS_NONSEQ && dp_valid) overlap_cnt <= overlap_cnt + 1;
        if (!rst) begin
            dp_valid  <= 1'b0;
            dp_err    <= 1'b0;
            hready    <= 1'b1;
            hresp     <= 1'b0;
            err_phase <= 1'b0;
            wait_left <= 0;
        end else if (hready) begin
            if (dp_valid && dp_write && !dp_err) obs_q.push_back({dp_addr, hwdata});
            nerr = err_en && htrans == HTRANS_NONSEQ && hwrite && haddr == err_addr;
            dp_valid <= (htrans == HTRANS_NONSEQ);
            dp_addr  <= haddr;
            dp_write <= hwrite;
            dp_err   <= nerr;
            if (htrans == HTRANS_NONSEQ && !hwrite) hrdata <= rom[haddr[3:2]];
            if (nerr) begin
                hready    <= 1'b0;
                hresp     <= 1'b1;
                err_phase <= 1'b1;
            end else begin
                w = $urandom_range(max_wait);
                hready    <= (w == 0);
                wait_left <= (w == 0) ? 0 : w - 1;
                hresp     <= 1'b0;
            end
        end else begin
            if (err_phase) begin
                hready    <= 1'b1;
                err_phase <= 1'b0;
            end else if (wait_left == 0) begin
                hready <= 1'b1;
            end else begin
                wait_left <= wait_left - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (htrans_z != HTRANS_IDLE) zero_traffic <= zero_traffic + 1;
        if (rst && htrans_w == HTRANS_NONSEQ && hwrite_w) waddr_q.push_back(haddr_w);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
            $display("check %s: got %h expected %h", tag, got, exp);
        end else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({32'h8000_0000 + 32'(4 * i), rom[i]});
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start_z = 1'b0; start_w = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_htrans", htrans, HTRANS_IDLE);
        check("rst_hsel", hsel, 0);
        check("rst_haddr", haddr, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_hwrite", hwrite, 0);
        check("rst_flags", {busy, done, error, core_hold}, 4'b0001);
        check("rst_fixed", {hsize, hburst, hprot, hmastlock}, {3'b010, 3'b000, 4'b0011, 1'b0});
        rst = 1'b1;
        @(negedge clk);

        // zero-wait copy
        push_exp(4);
        pulse_start();
        check("latency_htrans", htrans, HTRANS_NONSEQ);
        check("latency_haddr", haddr, 32'h0);
        check("latency_hold", core_hold, 1);
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        check("done_cycle", cyc, 16);
        check("hold_fall", core_hold, 0);
        check_writes("zero_wait");

        // random wait states
        max_wait = 3;
        push_exp(4);
        pulse_start();
        cyc = 0;
        while (!done && cyc < 400) begin @(negedge clk); cyc++; end
        check("waits_done", done, 1);
        check_writes("waits");
        check("no_overlap", overlap_cnt, 0);

        // error response on write of word 2
        max_wait = 0;
        err_en = 1'b1;
        push_exp(2);
        pulse_start();
        cyc = 0;
        while (!error && cyc < 200) begin @(negedge clk); cyc++; end
        check("err_flags", {busy, done, error, core_hold}, 4'b0011);
        check_writes("err");
        nz = 0;
        repeat (10) begin @(negedge clk); if (htrans != HTRANS_IDLE) nz++; end
        check("err_quiet", nz, 0);
        err_en = 1'b0;
        push_exp(4);
        pulse_start();
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        check("retry_flags", {done, error, core_hold}, 3'b100);
        check_writes("retry");

        // asynchronous reset during RD_DATA of word 1
        pulse_start();
        cyc = 0;
        while (!(htrans == HTRANS_NONSEQ && !hwrite && haddr == 32'h4) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        check("found_rd1", cyc < 100, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_bus", {htrans, hsel, hwrite}, 4'b0000);
        check("arst_haddr", haddr, 0);
        check("arst_hwdata", hwdata, 0);
        check("arst_flags", {busy, done, error, core_hold}, 4'b0001);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        @(negedge clk);
        push_exp(4);
        pulse_start();
        check("restart_addr", {htrans, hwrite, haddr}, {HTRANS_NONSEQ, 1'b0, 32'h0});
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        check("restart_done", done, 1);
        check_writes("restart");

        // zero-word instance
        check("zero_idle", done_z, 0);
        @(negedge clk); start_z = 1'b1;
        @(negedge clk); start_z = 1'b0;
        check("zero_done", {done_z, busy_z, hold_z}, 3'b100);
        repeat (3) @(negedge clk);
        check("zero_traffic", zero_traffic, 0);

        // address wrap instance
        waddr_q.delete();
        wexp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        @(negedge clk); start_w = 1'b1;
        @(negedge clk); start_w = 1'b0;
        cyc = 0;
        while (!done_w && cyc < 200) begin @(negedge clk); cyc++; end
        check("wrap_done", done_w, 1);
        check("wrap_count", 64'(waddr_q.size()), 64'(wexp_q.size()));
        while (waddr_q.size() > 0 && wexp_q.size() > 0)
            check("wrap_addr", waddr_q.pop_front(), wexp_q.pop_front());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
